// File: rtl/ex_mc_sequencer.sv
// EX-stage sequencer for multi-cycle units (CLZ, MULT, DIV, DIVU): latch, start, stall, capture.
// Optional watchdog on WAIT/DRAIN is built when MC_TIMEOUT_EN is defined.
module ex_mc_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ex_valid,
  input  logic [1:0]   ex_op,
  input  logic [31:0]  rs_value,
  input  logic [31:0]  rt_value,
  input  logic         flush,
  output logic [3:0]   unit_start,
  output logic [31:0]  unit_a,
  output logic [31:0]  unit_b,
  input  logic [3:0]   unit_busy,
  input  logic [127:0] unit_lo,
  input  logic [127:0] unit_hi,
  output logic         stall,
  output logic         res_valid,
  output logic [31:0]  res_lo,
  output logic [31:0]  res_hi,
  output logic         timeout_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;

  logic        accept;
  logic        sel_busy;
  logic [31:0] sel_lo;
  logic [31:0] sel_hi;
  logic        expired;

  assign accept   = ex_valid && !flush;
  assign sel_busy = unit_busy[op_q];
  assign sel_lo   = unit_lo[{op_q, 5'd0} +: 32];
  assign sel_hi   = unit_hi[{op_q, 5'd0} +: 32];

`ifdef MC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  // Fires on the last permitted WAIT/DRAIN cycle so the exit lands after exactly TIMEOUT_CYCLES.
  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) && ((state_d == S_WAIT) || (state_d == S_DRAIN)))
      cnt_d = '0;
    else if ((state_q == S_WAIT) || (state_q == S_DRAIN))
      cnt_d = cnt_q + 1'b1;
  end

  assign to_d        = (state_q == S_WAIT) && !flush && sel_busy && expired;
  assign timeout_err = to_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = ex_op;
          a_d     = rs_value;
          b_d     = rt_value;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = flush ? S_IDLE : S_WAIT;
      S_WAIT: begin
        // Flush wins over completion: a squashed instruction must not commit a result.
        if (flush) begin
          state_d = S_DRAIN;
        end else if (!sel_busy) begin
          lo_d    = sel_lo;
          hi_d    = sel_hi;
          state_d = S_DONE;
        end else if (expired) begin
          lo_d    = '0;
          hi_d    = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: begin
        if (!sel_busy || expired) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      S_IDLE:           stall = accept;
      S_LAUNCH, S_WAIT: stall = 1'b1;
      S_DRAIN:          stall = ex_valid;
      default:          stall = 1'b0;
    endcase
  end

  assign unit_start = ((state_q == S_LAUNCH) && !flush) ? (4'b0001 << op_q) : 4'b0000;
  assign unit_a     = a_q;
  assign unit_b     = b_q;
  assign res_valid  = (state_q == S_DONE);
  assign res_lo     = lo_q;
  assign res_hi     = hi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: doc/ex_mc_sequencer.md
# ex_mc_sequencer

EX-stage sequencer for the multi-cycle execution units: CLZ counter, multiplier and dividers. It sits between the ID/EX pipeline register and those units. It latches operands, issues a one-cycle `start`, stalls the pipeline while the selected unit reports `busy`, then captures the unit result into a holding register for the EX/MEM register. Combinational units (`busy` tied low) and true multi-cycle units use the same handshake.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum WAIT cycles before the watchdog fires (watchdog built only with `MC_TIMEOUT_EN`).

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_valid`  in  1  instruction in EX needs a multi-cycle unit.
- `ex_op`  in  2  unit select: 0 CLZ, 1 MULT, 2 DIV, 3 DIVU.
- `rs_value`  in  32  operand A.
- `rt_value`  in  32  operand B.
- `flush`  in  1  EX-stage flush (branch/exception).
- `unit_start`  out  4  one-hot start pulse, bit index = `ex_op`.
- `unit_a`, `unit_b`  out  32 each  latched operands to all units.
- `unit_busy`  in  4  per-unit busy.
- `unit_lo`  in  4×32 (128, unit n at [32n+31:32n])  per-unit low result (CLZ result on lo).
- `unit_hi`  in  4×32 (128)  per-unit high result (CLZ drives 0).
- `stall`  out  1  hold IF/ID/EX.
- `res_valid`  out  1  one-cycle pulse, `res_lo`/`res_hi` valid.
- `res_lo`, `res_hi`  out  32 each  captured result, held until next capture.
- `timeout_err`  out  1  one-cycle watchdog pulse.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE, DRAIN.
- IDLE: if `ex_valid && !flush`, latch `ex_op`, `rs_value`, `rt_value` and go to LAUNCH. `stall` = `ex_valid && !flush` (Mealy).
- LAUNCH: `unit_start[op]`=1 for exactly this cycle; `stall`=1; go to WAIT.
- WAIT: `stall`=1. If `!unit_busy[op]`, capture `unit_lo[op]`/`unit_hi[op]` into `res_lo`/`res_hi` and go to DONE. Otherwise stay.
- DONE: `stall`=0, `res_valid`=1; the pipeline advances at this edge; go to IDLE. The new `ex_valid` is not sampled in DONE.
- `flush` in LAUNCH: suppress `start`, go to IDLE.
- `flush` in WAIT: go to DRAIN without capture. DONE ignores `flush` (result already committed).
- DRAIN: wait for `!unit_busy[op]`, then go to IDLE. `stall` = `ex_valid`; `res_valid` stays 0.
- `unit_busy` is sampled only in WAIT/DRAIN, i.e. at least one cycle after `start`. A unit with `busy` stuck low completes with minimum latency.
- Unselected `unit_start` bits are always 0. `unit_a`/`unit_b` are held constant from LAUNCH until the state leaves WAIT/DRAIN.

## Timing
- Reset values: state IDLE, `unit_start`=0, `unit_a`=`unit_b`=0, `stall`=0 (outside IDLE-Mealy term), `res_valid`=0, `res_lo`=`res_hi`=0, `timeout_err`=0. Watchdog counter = 0.
- Asynchronous reset mid-operation aborts immediately: no `res_valid`, no `start`.
- Minimum latency, `ex_valid` in cycle 0 with a combinational unit: LAUNCH cycle 1, WAIT cycle 2, `res_valid` cycle 3. `stall` is high in cycles 0–2.
- A unit holding `busy` for N cycles after `start` adds N cycles in WAIT.
- Back-to-back multi-cycle instructions: the second is launched from IDLE in the cycle after DONE.

## Configuration
- `MC_TIMEOUT_EN` defined: a counter increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES`, go to DONE with `res_lo`=`res_hi`=0, `res_valid`=1 and `timeout_err`=1 in the same cycle. DRAIN is also bounded by `TIMEOUT_CYCLES` and exits to IDLE silently. The counter clears on entering WAIT/DRAIN.
- Not defined: no counter; WAIT/DRAIN wait indefinitely; `timeout_err` tied 0.

## Test plan
- CLZ, `busy` low, `rs_value`=0x0000_0001 -> `unit_start`=4'b0001 in cycle 1; `res_lo`=31, `res_hi`=0 with `res_valid` in cycle 3; `stall` high exactly cycles 0–2.
- DIV op 2, `busy` high 33 cycles after `start`, `unit_lo[2]`=7, `unit_hi[2]`=3 -> `res_valid` in cycle 36 with lo=7, hi=3; `unit_a`/`unit_b` stable throughout.
- `flush` in LAUNCH -> no `start` pulse, IDLE next cycle, no `res_valid`. `flush` in WAIT with `busy` 5 more cycles -> DRAIN; `stall` follows `ex_valid`; IDLE after `busy` drops; `res_lo` retains its old value.
- Two back-to-back CLZ ops (0x8000_0000, then 0) -> `res_valid` cycles 3 and 7, `res_lo`=0 then 32.
- `rst_n` low during WAIT -> all outputs at reset values immediately; new op after release completes normally.
- `MC_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `busy` stuck high -> `res_valid`+`timeout_err` with `res_lo`=`res_hi`=0 after 8 WAIT cycles.
